// File: rtl/qix_link_pkg.sv
// Shared register offsets and field positions for the inter-CPU doorbell/mailbox link.
package qix_link_pkg;

    localparam logic [2:0] AddrStatus = 3'd0;
    localparam logic [2:0] AddrAck    = 3'd1;
    localparam logic [2:0] AddrRing   = 3'd2;
    localparam logic [2:0] AddrMask   = 3'd3;
    localparam logic [2:0] AddrMbox   = 3'd4;
    localparam logic [2:0] AddrMbctl  = 3'd5;

    localparam int unsigned MboxOvfBit     = 7;
    localparam int unsigned MbctlFlushBit  = 0;
    localparam int unsigned MbctlClrOvfBit = 7;

endpackage

// File: rtl/qix_link_fifo.sv
// Mailbox FIFO: power-of-two depth, synchronous flush, pop on empty ignored,
// push on full accepted only when a pop frees the slot in the same cycle.
module qix_link_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_20m,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk_20m) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_20m) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/qix_cpu_link.sv
// Inter-CPU link: doorbell channels with masked IRQ, ring pulses and a mailbox FIFO.
// Define DOORBELL_COUNT_EN to replace the per-channel pending latch with a saturating counter.
module qix_cpu_link
    import qix_link_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned PULSE_LEN  = 4,
    parameter int unsigned MBOX_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic              clk_20m,
    input  logic              reset,
    input  logic              bus_stb,
    input  logic              bus_rnw,
    input  logic [2:0]        bus_addr,
    input  logic [7:0]        bus_wdata,
    output logic [7:0]        bus_rdata,
    input  logic [NUM_CH-1:0] remote_n,
    output logic [NUM_CH-1:0] ring,
    output logic              irq_n,
    output logic [7:0]        mbox_data,
    output logic              mbox_valid,
    input  logic              mbox_ready
);

    localparam int unsigned LW = $clog2(MBOX_DEPTH) + 1;

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH out of range");
    end
    if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
        $error("PULSE_LEN out of range");
    end
    if (MBOX_DEPTH < 2 || MBOX_DEPTH > 16 || (1 << $clog2(MBOX_DEPTH)) != MBOX_DEPTH)
    begin : g_bad_depth
        $error("MBOX_DEPTH must be a power of two in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic              wr;
    logic [NUM_CH-1:0] ack, ring_set, set_ev, pend;
    logic [NUM_CH-1:0] meta_q, sync_q, sync_dly_q;
    logic [NUM_CH-1:0] mask_q;
    logic              irq_n_q;
    logic [3:0]        ring_cnt_q [NUM_CH];
    logic              ovf_q;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [LW-1:0]     fifo_level;

    assign wr       = bus_stb & ~bus_rnw;
    assign ack      = (wr && bus_addr == AddrAck)  ? bus_wdata[NUM_CH-1:0] : '0;
    assign ring_set = (wr && bus_addr == AddrRing) ? bus_wdata[NUM_CH-1:0] : '0;
    // Falling edge seen on the already-synchronised level.
    assign set_ev   = sync_dly_q & ~sync_q;

    always_ff @(posedge clk_20m) begin
        if (reset) begin
            meta_q     <= '1;
            sync_q     <= '1;
            sync_dly_q <= '1;
        end else begin
            meta_q     <= remote_n;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

`ifdef DOORBELL_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk_20m) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else if (set_ev[i] && !ack[i]) begin
                if (cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (ack[i] && !set_ev[i]) begin
                if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_CH; i++) pend[i] = (cnt_q[i] != '0);
    end
`else
    logic [NUM_CH-1:0] pend_q;

    always_ff @(posedge clk_20m) begin
        if (reset) pend_q <= '0;
        else       pend_q <= set_ev | (pend_q & ~ack);
    end

    assign pend = pend_q;
`endif

    always_ff @(posedge clk_20m) begin
        if (reset) begin
            mask_q  <= '0;
            irq_n_q <= 1'b1;
        end else begin
            if (wr && bus_addr == AddrMask) mask_q <= bus_wdata[NUM_CH-1:0];
            irq_n_q <= ~|(pend & mask_q);
        end
    end

    assign irq_n = irq_n_q;

    // A re-ring reloads the counter, restarting the pulse.
    always_ff @(posedge clk_20m) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset)                 ring_cnt_q[i] <= '0;
            else if (ring_set[i])      ring_cnt_q[i] <= 4'(PULSE_LEN);
            else if (ring_cnt_q[i] != '0) ring_cnt_q[i] <= ring_cnt_q[i] - 1'b1;
        end
    end

    always_comb begin
        ring = '0;
        for (int i = 0; i < NUM_CH; i++) ring[i] = (ring_cnt_q[i] != '0);
    end

    assign fifo_push  = wr && bus_addr == AddrMbox;
    assign fifo_pop   = mbox_valid & mbox_ready;
    assign fifo_flush = wr && bus_addr == AddrMbctl && bus_wdata[MbctlFlushBit];

    always_ff @(posedge clk_20m) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr && bus_addr == AddrMbctl && bus_wdata[MbctlClrOvfBit]) begin
            ovf_q <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end
    end

    qix_link_fifo #(
        .DEPTH (MBOX_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_20m (clk_20m),
        .reset   (reset),
        .push    (fifo_push),
        .wdata   (bus_wdata),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .rdata   (mbox_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign mbox_valid = ~fifo_empty;

    always_comb begin
        bus_rdata = 8'hFF;
        case (bus_addr)
            AddrStatus: bus_rdata = 8'(pend);
            AddrAck:    bus_rdata = 8'h00;
            AddrRing:   bus_rdata = 8'h00;
            AddrMask:   bus_rdata = 8'(mask_q);
            AddrMbox: begin
                bus_rdata = {4'b0000, 4'(fifo_level)};
                bus_rdata[MboxOvfBit] = ovf_q;
            end
            AddrMbctl:  bus_rdata = 8'h00;
            default:    bus_rdata = 8'hFF;
        endcase
    end

endmodule
